mod_chain_counter: RTL
======================

MOD_CHAIN_COUNTER -- requirements
Module: mod_chain_counter

Interface
REQ-001 Parameter N, default 10: modulus of each digit, legal range N>=2.
REQ-002 Parameter W, default 4: bits per digit, legal when W>=ceil(log2(N)).
REQ-003 Parameter DIGITS, default 3: number of cascaded digits, legal when DIGITS>=1.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port clr, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port ci, input, 1 bit: count enable, also the carry/borrow in from a lower chain.
REQ-007 Port dir, input, 1 bit: count direction, 0 counts up and 1 counts down.
REQ-008 Port ld, input, 1 bit: synchronous parallel load strobe.
REQ-009 Port d, input, DIGITS*W bits: load value; digit k occupies bits [k*W+W-1:k*W].
REQ-010 Port q, output, DIGITS*W bits: registered count, same packing as d, digit 0 least significant.
REQ-011 Port co, output, 1 bit: combinational carry/borrow out to the next chain.
REQ-012 Port tc, output, 1 bit: combinational terminal count; all digits are N-1 when dir=0, or all digits are 0 when dir=1.

Function
REQ-013 Priority per edge SHALL be clr, then ld, then ci; when none is asserted, q holds.
REQ-014 On ld (with clr=0), each digit SHALL take its slice of d; any slice >=N SHALL load as 0.
REQ-015 Counting up (ci=1, dir=0): digit k SHALL advance when every lower digit equals N-1; N-1 wraps to 0, otherwise +1.
REQ-016 Counting down (ci=1, dir=1): digit k SHALL advance when every lower digit equals 0; 0 wraps to N-1, otherwise -1.
REQ-017 Digit 0 SHALL advance on every counting cycle.
REQ-018 Whole-chain wrap: up from all N-1 SHALL give all 0; down from all 0 SHALL give all N-1.
REQ-019 co = ci & tc & ~clr & ~ld, valid in the same cycle with zero latency.
REQ-020 tc SHALL depend only on q and dir, not on ci.
REQ-021 Changing dir between cycles SHALL take effect on the next edge without any idle cycle.
REQ-022 Chains connected by co-to-ci with a common clk, clr and dir SHALL count as one wider counter.
REQ-023 Digit values >=N SHALL never appear on q.

Reset
REQ-024 When clr=1 at an edge, q SHALL become 0 regardless of ld, ci, dir and d.
REQ-025 Asserting clr mid-count SHALL abandon the count; counting resumes from 0 on the first edge with clr=0 and ci=1.
REQ-026 The power-up value of q SHALL be 0 before the first clr.
REQ-027 While clr=1, co SHALL be 0; tc follows q=0 (1 when dir=1, 0 when dir=0 with N>=2).

Configuration
REQ-028 Macro MOD_CHAIN_COUNTER_LAP_EN SHALL, when defined, add input lap (1 bit) and output lap_q (DIGITS*W bits, registered).
REQ-029 With the macro defined, lap=1 at an edge SHALL capture the pre-edge q into lap_q while counting continues unaffected.
REQ-030 With the macro defined, clr SHALL zero lap_q and take priority over lap; ld SHALL not affect lap_q.
REQ-031 Without the macro, lap and lap_q SHALL be absent and behaviour SHALL be identical to REQ-013..REQ-027.

Verification (N=10, W=4, DIGITS=3; q shown as hex digits)
REQ-032 Up wrap: clr, then ci=1, dir=0 for 999 edges -> q=0x999 and tc=1, co=1 while ci=1; next edge -> q=0x000, co=0.
REQ-033 Down wrap: q=0x000, dir=1, ci=1 -> tc=1 and co=1 in that cycle; next edge q=0x999; next edge q=0x998.
REQ-034 Load priority: ld=1, ci=1, d=0x459 -> q=0x459 and co=0 during ld; then ci=1 for one edge -> q=0x460.
REQ-035 Invalid load: ld=1, d=0x0A3 -> q=0x003.
REQ-036 Reset priority: clr=1, ld=1, ci=1, d=0x777 -> q=0x000, co=0; clr at q=0x512 mid-count -> q=0x000 on that edge.
REQ-037 Lap (macro defined): lap=1 when q=0x123 with counting -> lap_q=0x123 and q=0x124 after the edge; clr -> lap_q=0x000.

Source files
------------

// File: rtl/mod_chain_counter.sv
// Cascadable modulo-N up/down counter of DIGITS digits, each W bits wide.
// Optional lap register enabled by defining MOD_CHAIN_COUNTER_LAP_EN.
module mod_chain_counter #(
  parameter int N      = 10,
  parameter int W      = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ci,
  input  logic                  dir,
  input  logic                  ld,
  input  logic [DIGITS*W-1:0]   d,
  output logic [DIGITS*W-1:0]   q,
  output logic                  co,
  output logic                  tc
`ifdef MOD_CHAIN_COUNTER_LAP_EN
  , input  logic                lap
  , output logic [DIGITS*W-1:0] lap_q
`endif
);

  localparam logic [W-1:0] MAX   = W'(N - 1);
  localparam logic [W:0]   N_EXT = (W + 1)'(N);

  // Declaration initialisers give the zero power-up state before any clr.
  logic [DIGITS-1:0][W-1:0] cnt = '0;
  logic [DIGITS-1:0][W-1:0] cnt_step;
  logic [DIGITS-1:0][W-1:0] load_val;
  logic [DIGITS-1:0][W-1:0] d_dig;
  logic                     all_end;

  assign d_dig = d;

  always_comb begin
    logic en;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_step = cnt;
    load_val = '0;
    // NOTE: blocking '=' here is intentional; en ripples digit to digit within one evaluation.
    en       = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (en) begin
        if (dir) cnt_step[k] = (cnt[k] == '0)  ? MAX : cnt[k] - W'(1);
        else     cnt_step[k] = (cnt[k] == MAX) ? '0  : cnt[k] + W'(1);
      end
      en = en & (dir ? (cnt[k] == '0) : (cnt[k] == MAX));
      // Out-of-range load digits collapse to zero so q never shows an illegal digit.
      load_val[k] = ({1'b0, d_dig[k]} >= N_EXT) ? '0 : d_dig[k];
    end
    all_end = en;
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (ld) cnt <= load_val;
    else if (ci) cnt <= cnt_step;
  end

  assign q  = cnt;
  assign tc = all_end;
  assign co = ci & all_end & ~clr & ~ld;

`ifdef MOD_CHAIN_COUNTER_LAP_EN
  logic [DIGITS*W-1:0] lap_r = '0;

  always_ff @(posedge clk) begin
    if (clr)      lap_r <= '0;
    else if (lap) lap_r <= cnt;
  end

  assign lap_q = lap_r;
`endif

endmodule
